// File: rtl/fractcam_pkg.sv
// ----------------------------------------------------------------------------
// fractcam_pkg
// Shared constants and helpers for the fractured-CAM match encoder.
//   GROUP_W   : entries per priority-encode group (matches the 4-entry slice
//               granularity of the match-combine stage)
//   idx_width : width of an entry index for a CAM of the given depth
// ----------------------------------------------------------------------------
package fractcam_pkg;

    localparam int GROUP_W = 4;

    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fractcam_prio_enc4.sv
// ----------------------------------------------------------------------------
// fractcam_prio_enc4
// Combinational 4-bit priority encoder; bit 0 has the highest priority.
// Ports:
//   i_bits  in  4  match bits of one group
//   o_hit   out 1  any bit set
//   o_idx   out 2  position of the lowest set bit (0 when no bit set)
//   o_multi out 1  two or more bits set
// ----------------------------------------------------------------------------
module fractcam_prio_enc4
    import fractcam_pkg::*;
(
    input  logic [GROUP_W-1:0] i_bits,
    output logic               o_hit,
    output logic [1:0]         o_idx,
    output logic               o_multi
);

    assign o_hit = |i_bits;

    // Clearing the lowest set bit leaves something only if another bit was set.
    assign o_multi = |(i_bits & (i_bits - 4'd1));

    always_comb begin
        o_idx = 2'd0;
        if      (i_bits[0]) o_idx = 2'd0;
        else if (i_bits[1]) o_idx = 2'd1;
        else if (i_bits[2]) o_idx = 2'd2;
        else if (i_bits[3]) o_idx = 2'd3;
    end

endmodule

// File: rtl/fractcam_match_encoder.sv
// ----------------------------------------------------------------------------
// fractcam_match_encoder
// Turns the D-bit combined match vector of the fractured CAM into a hit flag
// and the lowest matching entry index. Two registered stages:
//   stage 1 : per-group (4-entry) priority encode
//   stage 2 : lowest hitting group wins, result lands in the m_* registers
// Valid/ready on both sides; one lookup per cycle when m_ready stays high.
//
// Ports:
//   clk      in   1      clock
//   rst_n    in   1      asynchronous active-low reset
//   s_match  in   D      combined match vector, bit i = entry i matches
//   s_valid  in   1      s_match valid
//   s_ready  out  1      encoder can accept s_match this cycle
//   m_hit    out  1      at least one entry matched
//   m_index  out  IDX_W  lowest matching entry index, 0 on miss
//   m_valid  out  1      result valid
//   m_ready  in   1      downstream accepts result
//   m_multi  out  1      more than one entry matched
//
// Build option: define FRACTCAM_MULTI_HIT_EN to add the m_multi output and
// its logic; without it the port is absent.
// ----------------------------------------------------------------------------
module fractcam_match_encoder
    import fractcam_pkg::*;
#(
    parameter  int D     = 64,
    localparam int IDX_W = idx_width(D),
    localparam int NG    = D / GROUP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [D-1:0]     s_match,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             m_hit,
    output logic [IDX_W-1:0] m_index,
    output logic             m_valid,
    input  logic             m_ready
`ifdef FRACTCAM_MULTI_HIT_EN
    ,
    output logic             m_multi
`endif
);

    if ((D % GROUP_W) != 0 || D < 8) begin : g_bad_depth
        $error("fractcam_match_encoder: D=%0d must be a multiple of 4 and >= 8", D);
    end

    // ------------------------------------------------------------------
    // Handshake: each stage advances when the stage after it can take data.
    // ------------------------------------------------------------------
    logic w_adv1;
    logic w_adv2;
    logic r_s1_valid;

    assign w_adv2  = ~m_valid | m_ready;
    assign w_adv1  = ~r_s1_valid | w_adv2;
    assign s_ready = w_adv1;

    // ------------------------------------------------------------------
    // Stage 1: group encode
    // ------------------------------------------------------------------
    logic [NG-1:0]      w_g_hit;
    logic [NG-1:0]      w_g_multi;
    logic [NG-1:0][1:0] w_g_idx;

    for (genvar g = 0; g < NG; g++) begin : g_enc
        fractcam_prio_enc4 u_enc (
            .i_bits  (s_match[GROUP_W*g +: GROUP_W]),
            .o_hit   (w_g_hit[g]),
            .o_idx   (w_g_idx[g]),
            .o_multi (w_g_multi[g])
        );
    end

    logic [NG-1:0]      r_g_hit;
    logic [NG-1:0][1:0] r_g_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_g_hit    <= '0;
            r_g_idx    <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= s_valid & s_ready;
            r_g_hit    <= w_g_hit;
            r_g_idx    <= w_g_idx;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: group reduce. Scanning from the top down lets the lowest
    // hitting group overwrite any higher one.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_index;
    logic             w_hit;

    always_comb begin
        w_index = '0;
        w_hit   = |r_g_hit;
        for (int g = NG - 1; g >= 0; g--) begin
            if (r_g_hit[g]) w_index = IDX_W'(GROUP_W * g) | IDX_W'(r_g_idx[g]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_hit   <= 1'b0;
            m_index <= '0;
        end else if (w_adv2) begin
            m_valid <= r_s1_valid;
            m_hit   <= w_hit;
            m_index <= w_index;
        end
    end

`ifdef FRACTCAM_MULTI_HIT_EN
    logic [NG-1:0] r_g_multi;
    logic          w_multi;
    logic          w_seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_g_multi <= '0;
        else if (w_adv1) r_g_multi <= w_g_multi;
    end

    // Multi-hit: two bits inside one group, or hits in two distinct groups.
    always_comb begin
        w_multi = |r_g_multi;
        w_seen  = 1'b0;
        for (int g = 0; g < NG; g++) begin
            if (r_g_hit[g] && w_seen) w_multi = 1'b1;
            w_seen = w_seen | r_g_hit[g];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      m_multi <= 1'b0;
        else if (w_adv2) m_multi <= w_multi;
    end
`else
    logic w_unused_multi;
    assign w_unused_multi = ^w_g_multi;
`endif

endmodule

// File: tb/tb_fractcam_match_encoder.sv
module tb_fractcam_match_encoder;

    localparam int D  = 64;
    localparam int IW = 6;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic [D-1:0]  s_match = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          m_hit;
    logic [IW-1:0] m_index;
    logic          m_valid;
    logic          m_ready = 1'b0;
`ifdef FRACTCAM_MULTI_HIT_EN
    logic          m_multi;
`endif

    fractcam_match_encoder #(.D(D)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_match (s_match),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_hit   (m_hit),
        .m_index (m_index),
        .m_valid (m_valid),
        .m_ready (m_ready)
`ifdef FRACTCAM_MULTI_HIT_EN
        ,
        .m_multi (m_multi)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          hit;
        logic [IW-1:0] idx;
        logic          multi;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_out    = 0;

    // Reference: scan every bit, keep the lowest set one, count set bits.
    function automatic exp_t model(input logic [D-1:0] v);
        exp_t e;
        int   cnt;
        e   = '0;
        cnt = 0;
        for (int i = D - 1; i >= 0; i--) begin
            if (v[i]) begin
                e.idx = IW'(i);
                cnt++;
            end
        end
        e.hit   = (cnt != 0);
        e.multi = (cnt >= 2);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Output side of the scoreboard: a transfer happens at the next posedge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && m_valid && m_ready) begin
            check("out_queue_nonempty", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("out_hit", 64'(m_hit), 64'(e.hit));
                check("out_idx", 64'(m_index), 64'(e.idx));
`ifdef FRACTCAM_MULTI_HIT_EN
                check("out_multi", 64'(m_multi), 64'(e.multi));
`endif
            end
            n_out++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs; the expected result is queued when the
    // transfer will be accepted at the coming edge.
    task automatic drive(input logic v, input logic [D-1:0] m, input logic mr, output logic acc);
        s_valid = v;
        s_match = m;
        m_ready = mr;
        #1;
        acc = v && s_ready;
        if (acc) q.push_back(model(m));
    endtask

    // One isolated lookup; the result registers one edge after stage 1.
    task automatic single(input string tag, input logic [D-1:0] v, input logic exp_hit,
                          input logic [IW-1:0] exp_idx, input logic exp_multi);
        logic acc;
        tick();
        drive(1'b1, v, 1'b1, acc);
        check({tag, "_accept"}, 64'(acc), 64'd1);
        tick();
        // s_match with s_valid low must be ignored
        drive(1'b0, '1, 1'b1, acc);
        check({tag, "_s1_not_out"}, 64'(m_valid), 64'd0);
        tick();
        check({tag, "_valid"}, 64'(m_valid), 64'd1);
        check({tag, "_hit"}, 64'(m_hit), 64'(exp_hit));
        check({tag, "_idx"}, 64'(m_index), 64'(exp_idx));
`ifdef FRACTCAM_MULTI_HIT_EN
        check({tag, "_multi"}, 64'(m_multi), 64'(exp_multi));
`else
        if (exp_multi === 1'bx) $display("note: unknown multi expectation in %s", tag);
`endif
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 50 && q.size() != 0; i++) tick();
        check({tag, "_drained"}, 64'(q.size()), 64'd0);
    endtask

    initial begin
        logic          acc;
        logic [D-1:0]  v;
        logic [D-1:0]  sv[8];
        logic [IW-1:0] held_idx;
        int            k;
        int            base;

        // Reset state
        #12;
        check("rst_s_ready", 64'(s_ready), 64'd1);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_hit",   64'(m_hit),   64'd0);
        check("rst_m_index", 64'(m_index), 64'd0);
`ifdef FRACTCAM_MULTI_HIT_EN
        check("rst_m_multi", 64'(m_multi), 64'd0);
`endif
        tick();
        rst_n = 1'b1;

        // Directed lookups and boundaries
        single("bit16",   64'h0000_0000_0001_0000, 1'b1, 6'd16, 1'b0);
        single("zero",    64'h0,                   1'b0, 6'd0,  1'b0);
        single("top",     64'h8000_0000_0000_0000, 1'b1, 6'd63, 1'b0);
        single("ones",    '1,                      1'b1, 6'd0,  1'b1);
        single("in_grp",  64'h0000_0000_0000_0003, 1'b1, 6'd0,  1'b1);
        single("x_grp",   64'h0000_0000_0000_0011, 1'b1, 6'd0,  1'b1);
        single("grp1",    64'h0000_0000_0000_0010, 1'b1, 6'd4,  1'b0);
        drain("directed");

        // Back-to-back random stream, m_ready held high
        base = n_out;
        for (int i = 0; i < 100; i++) begin
            tick();
            v = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            if (i % 10 == 3) v = '0;
            if (i % 10 == 7) v = v & {$urandom, $urandom} & {$urandom, $urandom};
            drive(1'b1, v, 1'b1, acc);
            check("rand_s_ready", 64'(acc), 64'd1);
        end
        tick();
        drive(1'b0, '0, 1'b1, acc);
        drain("rand");
        check("rand_count", 64'(n_out - base), 64'd100);

        // Stall: m_ready low for 5 cycles under a continuous stream
        for (int i = 0; i < 8; i++) sv[i] = 64'h1 << (i * 7 + 1) | 64'h1 << 62;
        base     = n_out;
        k        = 0;
        held_idx = model(sv[0]).idx;
        for (int c = 0; c < 40 && k < 8; c++) begin
            tick();
            if (c >= 2 && c <= 4) begin
                check("stall_s_ready", 64'(s_ready), 64'd0);
                check("stall_m_valid", 64'(m_valid), 64'd1);
                check("stall_m_idx",   64'(m_index), 64'(held_idx));
                check("stall_m_hit",   64'(m_hit),   64'd1);
            end
            drive(1'b1, sv[k], (c >= 5) ? 1'b1 : 1'b0, acc);
            if (acc) k++;
        end
        tick();
        drive(1'b0, '0, 1'b1, acc);
        check("stall_accepted", 64'(k), 64'd8);
        drain("stall");
        check("stall_count", 64'(n_out - base), 64'd8);

        // Asynchronous reset with both stages full
        tick();
        drive(1'b1, 64'h0000_0100_0000_0000, 1'b0, acc);
        tick();
        drive(1'b1, 64'h0000_0000_0000_0800, 1'b0, acc);
        tick();
        drive(1'b0, '0, 1'b0, acc);
        check("full_m_valid", 64'(m_valid), 64'd1);
        check("full_s_ready", 64'(s_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_m_valid", 64'(m_valid), 64'd0);
        check("arst_s_ready", 64'(s_ready), 64'd1);
        check("arst_m_index", 64'(m_index), 64'd0);
        q.delete();
        tick();
        rst_n = 1'b1;
        single("post_rst", 64'h0000_0000_2000_0000, 1'b1, 6'd29, 1'b0);
        drain("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
